// File: rtl/fewcore_rf_pkg.sv
// Shared defaults and FSM encoding for the
// register-file write controller.
package fewcore_rf_pkg;

  localparam int RF_XLEN    = 32;
  localparam int RF_AMOUNT  = 16;
  localparam int RF_ADDRLEN = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; pointer moves
// only when both inputs request together.
// Ports: clk, reset (sync, active-low), en,
// a_valid/b_valid in, a_grant/b_grant out.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant,
  output logic b_grant
);

  logic prio_b;
  logic both;

  assign both = a_valid & b_valid;

  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (en) begin
      if (both) begin
        a_grant = ~prio_b;
        b_grant = prio_b;
      end else begin
        a_grant = a_valid;
        b_grant = b_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prio_b <= 1'b0;
    end else if (en && both) begin
      prio_b <= ~prio_b;
    end
  end

endmodule

// File: rtl/regfile_controller.sv
// Register-file write controller: zeroes the file after reset,
// then arbitrates ALU/load writebacks and tracks pending writes.
// Ports: clk, reset (sync, active-low); issue_* from decode with
// issue_stall back; a_*/b_* writeback requests with a_ready/b_ready;
// wEn/rd/data registered write port; busy scoreboard; init_done.
module regfile_controller
  import fewcore_rf_pkg::*;
#(
  parameter int XLEN       = RF_XLEN,
  parameter int AMOUNT     = RF_AMOUNT,
  parameter int ADDRESSLEN = RF_ADDRLEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [ADDRESSLEN-1:0] issue_rd,
  input  logic [ADDRESSLEN-1:0] issue_rs1,
  input  logic [ADDRESSLEN-1:0] issue_rs2,
  input  logic                  issue_wb,
  output logic                  issue_stall,
  input  logic                  a_valid,
  input  logic [ADDRESSLEN-1:0] a_rd,
  input  logic [XLEN-1:0]       a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [ADDRESSLEN-1:0] b_rd,
  input  logic [XLEN-1:0]       b_data,
  output logic                  b_ready,
  output logic                  wEn,
  output logic [ADDRESSLEN-1:0] rd,
  output logic [XLEN-1:0]       data,
  output logic [AMOUNT-1:0]     busy,
  output logic                  init_done
);

  // One extra bit so the counter can reach AMOUNT,
  // marking that the last init write has been presented.
  localparam int CW = ADDRESSLEN + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_END = CW'(AMOUNT);

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic            run;
  logic            init_last;
  logic            accept;
  logic            grant_a;
  logic            grant_b;
  logic [AMOUNT-1:0] busy_q;
  logic [AMOUNT-1:0] busy_eff;
  logic [AMOUNT-1:0] busy_nx;

  assign run       = (state == RUN);
  assign init_last = (cnt == CNT_END);
  assign init_done = run;
  assign busy      = busy_q;
  assign a_ready   = grant_a;
  assign b_ready   = grant_b;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .en      (run),
    .a_valid (a_valid),
    .b_valid (b_valid),
    .a_grant (grant_a),
    .b_grant (grant_b)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= INIT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      INIT: if (init_last) state_nx = RUN;
      RUN:  state_nx = RUN;
      default: state_nx = INIT;
    endcase
  end

  always_comb begin
    busy_eff    = busy_q;
    busy_eff[0] = 1'b0;
    issue_stall = 1'b1;
    if (run) begin
      issue_stall = issue_valid
        & (busy_eff[issue_rs1]
         | busy_eff[issue_rs2]
         | (issue_wb & busy_eff[issue_rd]));
    end
  end

  assign accept = issue_valid & ~issue_stall;

  // Clear before set so an issue landing on the
  // write edge keeps its new pending bit.
  always_comb begin
    busy_nx = busy_q;
    if (wEn) busy_nx[rd] = 1'b0;
    if (accept && issue_wb && (issue_rd != '0)) begin
      busy_nx[issue_rd] = 1'b1;
    end
    busy_nx[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= CNT_ONE;
      wEn    <= 1'b0;
      rd     <= '0;
      data   <= '0;
      busy_q <= '0;
    end else begin
      wEn    <= 1'b0;
      busy_q <= busy_nx;
      if (!run) begin
        if (!init_last) begin
          wEn  <= 1'b1;
          rd   <= cnt[ADDRESSLEN-1:0];
          data <= '0;
          cnt  <= cnt + CNT_ONE;
        end
      end else if (grant_a) begin
        if (a_rd != '0) begin
          wEn  <= 1'b1;
          rd   <= a_rd;
          data <= a_data;
        end
      end else if (grant_b) begin
        if (b_rd != '0) begin
          wEn  <= 1'b1;
          rd   <= b_rd;
          data <= b_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_controller.sv
// Directed bench for regfile_controller with a
// behavioural register file on the write port.
module tb_regfile_controller;

  localparam int XLEN = 32;
  localparam int AMOUNT = 16;
  localparam int AL = 4;

  logic          clk;
  logic          reset;
  logic          issue_valid;
  logic [AL-1:0] issue_rd;
  logic [AL-1:0] issue_rs1;
  logic [AL-1:0] issue_rs2;
  logic          issue_wb;
  logic          issue_stall;
  logic          a_valid;
  logic [AL-1:0] a_rd;
  logic [XLEN-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [AL-1:0] b_rd;
  logic [XLEN-1:0] b_data;
  logic          b_ready;
  logic          wEn;
  logic [AL-1:0] rd;
  logic [XLEN-1:0] data;
  logic [AMOUNT-1:0] busy;
  logic          init_done;

  int checks;
  int failures;

  logic [XLEN-1:0] rf [AMOUNT];
  logic            rf_fill;

  regfile_controller #(
    .XLEN       (XLEN),
    .AMOUNT     (AMOUNT),
    .ADDRESSLEN (AL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_wb    (issue_wb),
    .issue_stall (issue_stall),
    .a_valid     (a_valid),
    .a_rd        (a_rd),
    .a_data      (a_data),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .b_rd        (b_rd),
    .b_data      (b_data),
    .b_ready     (b_ready),
    .wEn         (wEn),
    .rd          (rd),
    .data        (data),
    .busy        (busy),
    .init_done   (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: garbage-filled on demand so zeroing is observable.
  always @(posedge clk) begin
    if (rf_fill) begin
      for (int i = 0; i < AMOUNT; i++) rf[i] <= 32'hA5A5_0000 | i;
    end else if (wEn && rd != '0) begin
      rf[rd] <= data;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    rf_fill = 1'b1;
    tick;
    tick;
    rf_fill = 1'b0;
    a_valid = 1'b1;
    a_rd = 4'd9;
    a_data = 32'h1111_2222;
    #1;
    checks++;
    if ({wEn, rd, data} !== '0) begin
      failures++;
      $display("FAIL reset_port wEn=%0b rd=%0d data=%h want 0/0/0",
               wEn, rd, data);
    end
    checks++;
    if (busy !== '0 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state busy=%h init_done=%0b want 0/0",
               busy, init_done);
    end
    checks++;
    if (issue_stall !== 1'b1 || a_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs stall=%0b a_ready=%0b want 1/0",
               issue_stall, a_ready);
    end
  endtask

  task automatic test_init;
    reset = 1'b1;
    for (int i = 1; i < AMOUNT; i++) begin
      tick;
      checks++;
      if (wEn !== 1'b1 || rd !== AL'(i) || data !== '0
          || init_done !== 1'b0) begin
        failures++;
        $display("FAIL init_seq i=%0d wEn=%0b rd=%0d data=%h done=%0b want 1/%0d/0/0",
                 i, wEn, rd, data, init_done, i);
      end
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0 || issue_stall !== 1'b1) begin
        failures++;
        $display("FAIL init_hs i=%0d a_ready=%0b b_ready=%0b stall=%0b want 0/0/1",
                 i, a_ready, b_ready, issue_stall);
      end
    end
    a_valid = 1'b0;
    tick;
    checks++;
    if (init_done !== 1'b1 || wEn !== 1'b0) begin
      failures++;
      $display("FAIL init_done done=%0b wEn=%0b want 1/0", init_done, wEn);
    end
    for (int i = 1; i < AMOUNT; i++) begin
      checks++;
      if (rf[i] !== '0) begin
        failures++;
        $display("FAIL init_rf r%0d=%h want 0", i, rf[i]);
      end
    end
  endtask

  task automatic test_raw;
    issue_valid = 1'b1;
    issue_rd = 4'd5;
    issue_rs1 = 4'd0;
    issue_rs2 = 4'd0;
    issue_wb = 1'b1;
    #1;
    checks++;
    if (issue_stall !== 1'b0) begin
      failures++;
      $display("FAIL raw_issue stall=%0b want 0", issue_stall);
    end
    tick;
    issue_rd = 4'd6;
    issue_rs1 = 4'd5;
    #1;
    checks++;
    if (busy !== 16'h0020 || issue_stall !== 1'b1) begin
      failures++;
      $display("FAIL raw_dep busy=%h stall=%0b want 0020/1", busy, issue_stall);
    end
    tick;
    a_valid = 1'b1;
    a_rd = 4'd5;
    a_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (a_ready !== 1'b1 || issue_stall !== 1'b1) begin
      failures++;
      $display("FAIL raw_grant a_ready=%0b stall=%0b want 1/1", a_ready, issue_stall);
    end
    tick;
    a_valid = 1'b0;
    #1;
    checks++;
    if (wEn !== 1'b1 || rd !== 4'd5 || data !== 32'hDEAD_BEEF
        || issue_stall !== 1'b1) begin
      failures++;
      $display("FAIL raw_write wEn=%0b rd=%0d data=%h stall=%0b want 1/5/deadbeef/1",
               wEn, rd, data, issue_stall);
    end
    tick;
    checks++;
    if (wEn !== 1'b0 || busy !== '0 || issue_stall !== 1'b0) begin
      failures++;
      $display("FAIL raw_unstall wEn=%0b busy=%h stall=%0b want 0/0/0",
               wEn, busy, issue_stall);
    end
    checks++;
    if (rf[5] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL raw_rf r5=%h want deadbeef", rf[5]);
    end
    tick;
    issue_valid = 1'b0;
    b_valid = 1'b1;
    b_rd = 4'd6;
    b_data = 32'h0000_1234;
    #1;
    checks++;
    if (busy !== 16'h0040 || b_ready !== 1'b1) begin
      failures++;
      $display("FAIL raw_b busy=%h b_ready=%0b want 0040/1", busy, b_ready);
    end
    tick;
    b_valid = 1'b0;
    tick;
    checks++;
    if (busy !== '0 || rf[6] !== 32'h0000_1234) begin
      failures++;
      $display("FAIL raw_b_done busy=%h r6=%h want 0/1234", busy, rf[6]);
    end
  endtask

  task automatic test_round_robin;
    logic exp_a;
    a_valid = 1'b1;
    a_rd = 4'd1;
    a_data = 32'h11;
    b_valid = 1'b1;
    b_rd = 4'd2;
    b_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
      exp_a = (k % 2 == 0);
      #1;
      checks++;
      if (a_ready !== exp_a || b_ready !== !exp_a) begin
        failures++;
        $display("FAIL rr_grant k=%0d a_ready=%0b b_ready=%0b want %0b/%0b",
                 k, a_ready, b_ready, exp_a, !exp_a);
      end
      tick;
      checks++;
      if (wEn !== 1'b1 || rd !== (exp_a ? 4'd1 : 4'd2)) begin
        failures++;
        $display("FAIL rr_write k=%0d wEn=%0b rd=%0d want 1/%0d",
                 k, wEn, rd, exp_a ? 1 : 2);
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick;
    checks++;
    if (rf[1] !== 32'h11 || rf[2] !== 32'h22) begin
      failures++;
      $display("FAIL rr_rf r1=%h r2=%h want 11/22", rf[1], rf[2]);
    end
  endtask

  task automatic test_zero_write;
    b_valid = 1'b1;
    b_rd = 4'd0;
    b_data = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_grant b_ready=%0b a_ready=%0b want 1/0", b_ready, a_ready);
    end
    tick;
    b_valid = 1'b0;
    checks++;
    if (wEn !== 1'b0 || rd !== 4'd2 || data !== 32'h22) begin
      failures++;
      $display("FAIL zero_write wEn=%0b rd=%0d data=%h want 0/2/22",
               wEn, rd, data);
    end
  endtask

  task automatic test_same_edge;
    a_valid = 1'b1;
    a_rd = 4'd3;
    a_data = 32'h33;
    tick;
    a_valid = 1'b0;
    issue_valid = 1'b1;
    issue_rd = 4'd3;
    issue_rs1 = 4'd0;
    issue_rs2 = 4'd0;
    issue_wb = 1'b1;
    #1;
    checks++;
    if (wEn !== 1'b1 || rd !== 4'd3 || busy !== '0 || issue_stall !== 1'b0) begin
      failures++;
      $display("FAIL same_pre wEn=%0b rd=%0d busy=%h stall=%0b want 1/3/0/0",
               wEn, rd, busy, issue_stall);
    end
    tick;
    issue_valid = 1'b0;
    checks++;
    if (busy !== 16'h0008 || rf[3] !== 32'h33) begin
      failures++;
      $display("FAIL same_set busy=%h r3=%h want 0008/33", busy, rf[3]);
    end
  endtask

  task automatic test_reset_mid;
    issue_valid = 1'b1;
    issue_rd = 4'd7;
    issue_wb = 1'b1;
    tick;
    issue_valid = 1'b0;
    a_valid = 1'b1;
    a_rd = 4'd7;
    a_data = 32'h77;
    tick;
    a_valid = 1'b0;
    checks++;
    if (busy[7] !== 1'b1 || wEn !== 1'b1 || rd !== 4'd7) begin
      failures++;
      $display("FAIL mid_pending busy7=%0b wEn=%0b rd=%0d want 1/1/7",
               busy[7], wEn, rd);
    end
    reset = 1'b0;
    tick;
    checks++;
    if (busy !== '0 || wEn !== 1'b0 || rd !== '0 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset busy=%h wEn=%0b rd=%0d done=%0b want 0/0/0/0",
               busy, wEn, rd, init_done);
    end
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick;
      checks++;
      if (wEn !== 1'b1 || rd !== AL'(i) || data !== '0) begin
        failures++;
        $display("FAIL mid_reinit i=%0d wEn=%0b rd=%0d data=%h want 1/%0d/0",
                 i, wEn, rd, data, i);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    rf_fill = 1'b0;
    issue_valid = 1'b0;
    issue_rd = '0;
    issue_rs1 = '0;
    issue_rs2 = '0;
    issue_wb = 1'b0;
    a_valid = 1'b0;
    a_rd = '0;
    a_data = '0;
    b_valid = 1'b0;
    b_rd = '0;
    b_data = '0;
    test_reset;
    test_init;
    test_raw;
    test_round_robin;
    test_zero_write;
    test_same_edge;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
